// File: rtl/rx_block_decoder_64b66b.sv
// 64b/66b receive block decoder: turns descrambled 66-bit blocks into XGMII words.
// Define RX_DEC_ORDERED_SET_EN to decode ordered-set block types.
module rx_block_decoder_64b66b (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  s_axis_ttype,
    input  logic [63:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [63:0] m_axis_tdata,
    output logic [7:0]  m_axis_tctrl,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        blk_err
);
    typedef enum logic [1:0] {RX_INIT, RX_C, RX_D, RX_E} rx_state_t;
    typedef enum logic [2:0] {BLK_C, BLK_S, BLK_T, BLK_D, BLK_E} blk_type_t;

    localparam logic [63:0] EBLOCK_DATA = 64'hFEFE_FEFE_FEFE_FEFE;
    localparam logic [7:0]  EBLOCK_CTRL = 8'hFF;
    localparam logic [63:0] LBLOCK_DATA = 64'h0100_009C_0100_009C;
    localparam logic [7:0]  LBLOCK_CTRL = 8'h11;

    rx_state_t   state_q;
    logic        m_valid_q;
    logic [63:0] m_data_q;
    logic [7:0]  m_ctrl_q;
    logic        blk_err_q;

    blk_type_t   dec_type;
    logic [63:0] dec_data;
    logic [7:0]  dec_ctrl;
    logic [63:0] c_word;
    logic [7:0]  c_bad;
    logic [2:0]  term_k;
    logic        is_term;
    logic        term_bad;
    logic        accept;

    // Returns {invalid, xgmii_char} for a 7-bit control code.
    function automatic logic [8:0] map_code(input logic [6:0] code);
        case (code)
            7'h00:   map_code = {1'b0, 8'h07};
            7'h1E:   map_code = {1'b0, 8'hFE};
            default: map_code = {1'b1, 8'hFE};
        endcase
    endfunction

`ifdef RX_DEC_ORDERED_SET_EN
    logic [8:0] o0_m;
    logic [8:0] o4_m;

    function automatic logic [8:0] map_oset(input logic [3:0] code);
        case (code)
            4'h0:    map_oset = {1'b0, 8'h9C};
            4'hF:    map_oset = {1'b0, 8'h5C};
            default: map_oset = {1'b1, 8'h9C};
        endcase
    endfunction

    assign o0_m = map_oset(s_axis_tdata[35:32]);
    assign o4_m = map_oset(s_axis_tdata[39:36]);
`endif

    assign s_axis_tready = !m_valid_q || m_axis_tready;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tdata  = m_data_q;
    assign m_axis_tctrl  = m_ctrl_q;
    assign blk_err       = blk_err_q;

    // Every 7-bit code slot sits at 8+7i regardless of block type.
    always_comb begin
        c_word = '0;
        c_bad  = '0;
        for (int i = 0; i < 8; i++) begin
            {c_bad[i], c_word[8*i +: 8]} = map_code(s_axis_tdata[8 + 7*i +: 7]);
        end
    end

    always_comb begin
        is_term = 1'b1;
        case (s_axis_tdata[7:0])
            8'h87:   term_k = 3'd0;
            8'h99:   term_k = 3'd1;
            8'hAA:   term_k = 3'd2;
            8'hB4:   term_k = 3'd3;
            8'hCC:   term_k = 3'd4;
            8'hD2:   term_k = 3'd5;
            8'hE1:   term_k = 3'd6;
            8'hFF:   term_k = 3'd7;
            default: begin
                term_k  = 3'd0;
                is_term = 1'b0;
            end
        endcase
    end

    always_comb begin
        dec_type = BLK_E;
        dec_data = s_axis_tdata;
        dec_ctrl = '0;
        term_bad = 1'b0;
        if (s_axis_ttype == 2'b01) begin
            dec_type = BLK_D;
        end else if (s_axis_ttype == 2'b10) begin
            dec_ctrl = 8'hFF;
            case (s_axis_tdata[7:0])
                8'h1E: begin
                    dec_data = c_word;
                    dec_type = (|c_bad) ? BLK_E : BLK_C;
                end
                8'h78: begin
                    dec_data = {s_axis_tdata[63:8], 8'hFB};
                    dec_ctrl = 8'h01;
                    dec_type = BLK_S;
                end
                8'h33: begin
                    dec_data = {s_axis_tdata[63:40], 8'hFB, c_word[31:0]};
                    dec_ctrl = 8'h1F;
                    dec_type = (|c_bad[3:0]) ? BLK_E : BLK_S;
                end
`ifdef RX_DEC_ORDERED_SET_EN
                8'h2D: begin
                    dec_data = {s_axis_tdata[63:40], o4_m[7:0], c_word[31:0]};
                    dec_ctrl = 8'h1F;
                    dec_type = (|c_bad[3:0] || o4_m[8]) ? BLK_E : BLK_C;
                end
                8'h4B: begin
                    dec_data = {c_word[63:32], s_axis_tdata[31:8], o0_m[7:0]};
                    dec_ctrl = 8'hF1;
                    dec_type = (|c_bad[7:4] || o0_m[8]) ? BLK_E : BLK_C;
                end
                8'h55: begin
                    dec_data = {s_axis_tdata[63:40], o4_m[7:0], s_axis_tdata[31:8], o0_m[7:0]};
                    dec_ctrl = 8'h11;
                    dec_type = (o0_m[8] || o4_m[8]) ? BLK_E : BLK_C;
                end
                8'h66: begin
                    dec_data = {s_axis_tdata[63:40], 8'hFB, s_axis_tdata[31:8], o0_m[7:0]};
                    dec_ctrl = 8'h11;
                    dec_type = o0_m[8] ? BLK_E : BLK_S;
                end
`endif
                default: begin
                    if (is_term) begin
                        // Lanes below k carry data from bytes 1..k; pad bits are skipped.
                        dec_data = c_word;
                        for (int j = 0; j < 7; j++) begin
                            if (3'(j) < term_k) begin
                                dec_data[8*j +: 8] = s_axis_tdata[8*j + 8 +: 8];
                                dec_ctrl[j]        = 1'b0;
                            end
                        end
                        for (int j = 0; j < 8; j++) begin
                            if (3'(j) > term_k) term_bad = term_bad | c_bad[j];
                        end
                        dec_data[{term_k, 3'b000} +: 8] = 8'hFD;
                        dec_type = term_bad ? BLK_E : BLK_T;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= RX_INIT;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_ctrl_q  <= '0;
            blk_err_q <= 1'b0;
        end else begin
            blk_err_q <= 1'b0;
            if (accept) begin
                m_valid_q <= 1'b1;
                m_data_q  <= dec_data;
                m_ctrl_q  <= dec_ctrl;
                case (state_q)
                    RX_INIT: begin
                        if (dec_type == BLK_C) state_q <= RX_C;
                        else if (dec_type == BLK_S) state_q <= RX_D;
                        else begin
                            m_data_q  <= LBLOCK_DATA;
                            m_ctrl_q  <= LBLOCK_CTRL;
                            blk_err_q <= 1'b1;
                        end
                    end
                    RX_C: begin
                        if (dec_type == BLK_S) state_q <= RX_D;
                        else if (dec_type != BLK_C) begin
                            state_q   <= RX_E;
                            m_data_q  <= EBLOCK_DATA;
                            m_ctrl_q  <= EBLOCK_CTRL;
                            blk_err_q <= 1'b1;
                        end
                    end
                    RX_D: begin
                        if (dec_type == BLK_T) state_q <= RX_C;
                        else if (dec_type != BLK_D) begin
                            state_q   <= RX_E;
                            m_data_q  <= EBLOCK_DATA;
                            m_ctrl_q  <= EBLOCK_CTRL;
                            blk_err_q <= 1'b1;
                        end
                    end
                    default: begin
                        if (dec_type == BLK_C || dec_type == BLK_T) state_q <= RX_C;
                        else if (dec_type == BLK_D) state_q <= RX_D;
                        else begin
                            m_data_q  <= EBLOCK_DATA;
                            m_ctrl_q  <= EBLOCK_CTRL;
                            blk_err_q <= 1'b1;
                        end
                    end
                endcase
            end else if (m_axis_tready) begin
                m_valid_q <= 1'b0;
            end
        end
    end
endmodule
